// File: rtl/pc_unit.sv
// Program-counter unit for the multicycle MIPS datapath: PC/EPC/cause registers,
// next-PC selection, branch evaluation and single-level exception entry/return.
module pc_unit #(
  parameter int unsigned      WIDTH          = 32,
  parameter logic [WIDTH-1:0] INC            = 'd4,
  parameter logic [WIDTH-1:0] RESET_VECTOR   = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR_OPC = 'hFD,
  parameter logic [WIDTH-1:0] EXC_VECTOR_OVF = 'hFE,
  parameter logic [WIDTH-1:0] EXC_VECTOR_DIV = 'hFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_wr,
  input  logic             pc_wr_cond,
  input  logic [1:0]       pc_src,
  input  logic [1:0]       branch_type,
  input  logic             alu_zero,
  input  logic             alu_gt,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] reg_a,
  input  logic [25:0]      jump_index,
  input  logic [1:0]       exc_code,
  input  logic             eret,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] epc_out,
  output logic [1:0]       cause_out,
  output logic             exc_active,
  output logic             halted,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_EXC  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] pc_q, pc_n;
  logic [WIDTH-1:0] epc_q, epc_n;
  logic [1:0]       cause_q, cause_n;
  logic [WIDTH-1:0] src_val;
  logic [WIDTH-1:0] exc_vec;
  logic             taken;
  logic             exc_req;

  assign exc_req = (exc_code != 2'b00);

  always_comb begin
    src_val = pc_plus;
    case (pc_src)
      2'b00:   src_val = pc_plus;
      2'b01:   src_val = alu_result;
      2'b10:   src_val = {pc_q[WIDTH-1:28], jump_index, 2'b00};
      default: src_val = reg_a;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (branch_type)
      2'b00:   taken = alu_zero;
      2'b01:   taken = !alu_zero;
      2'b10:   taken = alu_gt;
      default: taken = !alu_gt;
    endcase
  end

  always_comb begin
    exc_vec = EXC_VECTOR_OPC;
    case (exc_code)
      2'b10:   exc_vec = EXC_VECTOR_OVF;
      2'b11:   exc_vec = EXC_VECTOR_DIV;
      default: exc_vec = EXC_VECTOR_OPC;
    endcase
  end

  // Priority: exception > eret > pc_wr > pc_wr_cond > hold. HALT ignores everything.
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    epc_n   = epc_q;
    cause_n = cause_q;
    case (state_q)
      ST_RUN: begin
        if (exc_req) begin
          pc_n    = exc_vec;
          epc_n   = pc_q - INC;
          cause_n = exc_code;
          state_n = ST_EXC;
        end else if (pc_wr) begin
          pc_n = src_val;
        end else if (pc_wr_cond && taken) begin
          pc_n = src_val;
        end
      end
      ST_EXC: begin
        if (exc_req) begin
          state_n = ST_HALT;
        end else if (eret) begin
          pc_n    = epc_q;
          state_n = ST_RUN;
        end else if (pc_wr) begin
          pc_n = src_val;
        end else if (pc_wr_cond && taken) begin
          pc_n = src_val;
        end
      end
      default: state_n = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      epc_q   <= epc_n;
      cause_q <= cause_n;
    end
  end

  assign pc_out     = pc_q;
  assign pc_plus    = pc_q + INC;
  assign epc_out    = epc_q;
  assign cause_out  = cause_q;
  assign exc_active = (state_q == ST_EXC);
  assign halted     = (state_q == ST_HALT);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: driver pushes hand-computed expected outputs into a
// queue, a monitor pops and compares them once the DUT outputs have settled.
module tb_pc_unit;

  localparam int W  = 32;
  localparam int EW = 3 * W + 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pc_wr = 1'b0, pc_wr_cond = 1'b0;
  logic [1:0]    pc_src = 2'b00, branch_type = 2'b00;
  logic          alu_zero = 1'b0, alu_gt = 1'b0;
  logic [W-1:0]  alu_result = '0, reg_a = '0;
  logic [25:0]   jump_index = '0;
  logic [1:0]    exc_code = 2'b00;
  logic          eret = 1'b0;
  logic [W-1:0]  pc_out, pc_plus, epc_out;
  logic [1:0]    cause_out, state_dbg;
  logic          exc_active, halted;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            vectors = 0;
  int            miscompares = 0;
  event          mon_ev;

  pc_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .pc_wr(pc_wr), .pc_wr_cond(pc_wr_cond),
    .pc_src(pc_src), .branch_type(branch_type), .alu_zero(alu_zero),
    .alu_gt(alu_gt), .alu_result(alu_result), .reg_a(reg_a),
    .jump_index(jump_index), .exc_code(exc_code), .eret(eret),
    .pc_out(pc_out), .pc_plus(pc_plus), .epc_out(epc_out),
    .cause_out(cause_out), .exc_active(exc_active), .halted(halted),
    .state_dbg(state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic idle();
    pc_wr = 1'b0; pc_wr_cond = 1'b0; pc_src = 2'b00; branch_type = 2'b00;
    alu_zero = 1'b0; alu_gt = 1'b0; alu_result = '0; reg_a = '0;
    jump_index = '0; exc_code = 2'b00; eret = 1'b0;
  endtask

  task automatic push_exp(input string nm, input logic [W-1:0] e_pc, input logic [W-1:0] e_epc,
                          input logic [1:0] e_cause, input logic e_exc, input logic e_halt);
    logic [W-1:0] e_plus;
    e_plus = e_pc + 32'd4;
    exp_q.push_back({e_pc, e_plus, e_epc, e_cause, e_exc, e_halt});
    name_q.push_back(nm);
  endtask

  task automatic step(input string nm, input logic wr, input logic cond, input logic [1:0] src,
                      input logic [1:0] bt, input logic z, input logic gt,
                      input logic [W-1:0] alu, input logic [W-1:0] ra, input logic [25:0] ji,
                      input logic [1:0] exc, input logic er,
                      input logic [W-1:0] e_pc, input logic [W-1:0] e_epc,
                      input logic [1:0] e_cause, input logic e_exc, input logic e_halt);
    @(negedge clk);
    pc_wr = wr; pc_wr_cond = cond; pc_src = src; branch_type = bt;
    alu_zero = z; alu_gt = gt; alu_result = alu; reg_a = ra;
    jump_index = ji; exc_code = exc; eret = er;
    @(posedge clk);
    push_exp(nm, e_pc, e_epc, e_cause, e_exc, e_halt);
    #1 ->mon_ev;
  endtask

  // Asserts reset away from any clock edge and checks outputs before the next edge.
  task automatic async_reset(input string nm);
    #2;
    idle();
    reset = 1'b0;
    #1;
    push_exp(nm, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    ->mon_ev;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Scoreboard monitor
  initial begin
    logic [EW-1:0] exp_v, act_v;
    string nm;
    forever begin
      @(mon_ev);
      while (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        act_v = {pc_out, pc_plus, epc_out, cause_out, exc_active, halted};
        vectors++;
        if (act_v !== exp_v) begin
          miscompares++;
          $display("FAIL %s: got pc=%h plus=%h epc=%h cause=%0d exc=%0b halt=%0b, required pc=%h plus=%h epc=%h cause=%0d exc=%0b halt=%0b",
                   nm, act_v[EW-1 -: W], act_v[EW-W-1 -: W], act_v[EW-2*W-1 -: W],
                   act_v[3:2], act_v[1], act_v[0],
                   exp_v[EW-1 -: W], exp_v[EW-W-1 -: W], exp_v[EW-2*W-1 -: W],
                   exp_v[3:2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  // Directed vectors
  initial begin
    idle();
    #3;
    push_exp("reset_state", 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    ->mon_ev;
    @(negedge clk);
    reset = 1'b1;

    //   name            wr cond src   bt    z  gt alu           ra            ji     exc  er  pc            epc           c  ex hl
    step("seq1",         1, 0, 2'd0, 2'd0, 0, 0, 32'h0,        32'h0,        26'h0, 2'd0, 0, 32'h4,        32'h0,        0, 0, 0);
    step("seq2",         1, 0, 2'd0, 2'd0, 0, 0, 32'h0,        32'h0,        26'h0, 2'd0, 0, 32'h8,        32'h0,        0, 0, 0);
    step("seq3",         1, 0, 2'd0, 2'd0, 0, 0, 32'h0,        32'h0,        26'h0, 2'd0, 0, 32'hC,        32'h0,        0, 0, 0);
    async_reset("async_reset_mid");

    step("load_reg_a",   1, 0, 2'd3, 2'd0, 0, 0, 32'h0,        32'hFFFFFFFC, 26'h0, 2'd0, 0, 32'hFFFFFFFC, 32'h0,        0, 0, 0);
    step("seq_wrap",     1, 0, 2'd0, 2'd0, 0, 0, 32'h0,        32'h0,        26'h0, 2'd0, 0, 32'h0,        32'h0,        0, 0, 0);
    step("beq_not",      0, 1, 2'd1, 2'd0, 0, 0, 32'h40,       32'h0,        26'h0, 2'd0, 0, 32'h0,        32'h0,        0, 0, 0);
    step("beq_taken",    0, 1, 2'd1, 2'd0, 1, 0, 32'h40,       32'h0,        26'h0, 2'd0, 0, 32'h40,       32'h0,        0, 0, 0);
    step("ble_not",      0, 1, 2'd1, 2'd3, 0, 1, 32'h80,       32'h0,        26'h0, 2'd0, 0, 32'h40,       32'h0,        0, 0, 0);
    step("bne_taken",    0, 1, 2'd1, 2'd1, 0, 0, 32'h80,       32'h0,        26'h0, 2'd0, 0, 32'h80,       32'h0,        0, 0, 0);
    step("bgt_taken",    0, 1, 2'd1, 2'd2, 0, 1, 32'hC0,       32'h0,        26'h0, 2'd0, 0, 32'hC0,       32'h0,        0, 0, 0);
    step("ble_taken",    0, 1, 2'd1, 2'd3, 0, 0, 32'h100,      32'h0,        26'h0, 2'd0, 0, 32'h100,      32'h0,        0, 0, 0);
    step("wr_beats_cond",1, 1, 2'd0, 2'd0, 1, 0, 32'h200,      32'h0,        26'h0, 2'd0, 0, 32'h104,      32'h0,        0, 0, 0);
    step("load_jump_pc", 1, 0, 2'd3, 2'd0, 0, 0, 32'h0,        32'h10000004, 26'h0, 2'd0, 0, 32'h10000004, 32'h0,        0, 0, 0);
    step("jump",         1, 0, 2'd2, 2'd0, 0, 0, 32'h0,        32'h0,        26'h10,2'd0, 0, 32'h10000040, 32'h0,        0, 0, 0);
    step("load_108",     1, 0, 2'd3, 2'd0, 0, 0, 32'h0,        32'h108,      26'h0, 2'd0, 0, 32'h108,      32'h0,        0, 0, 0);
    step("exc_ovf",      0, 0, 2'd0, 2'd0, 0, 0, 32'h0,        32'h0,        26'h0, 2'd2, 0, 32'hFE,       32'h104,      2, 1, 0);
    step("handler_seq",  1, 0, 2'd0, 2'd0, 0, 0, 32'h0,        32'h0,        26'h0, 2'd0, 0, 32'h102,      32'h104,      2, 1, 0);
    step("eret",         0, 0, 2'd0, 2'd0, 0, 0, 32'h0,        32'h0,        26'h0, 2'd0, 1, 32'h104,      32'h104,      2, 0, 0);
    step("eret_in_run",  0, 0, 2'd0, 2'd0, 0, 0, 32'h0,        32'h0,        26'h0, 2'd0, 1, 32'h104,      32'h104,      2, 0, 0);
    step("exc_beats_wr", 1, 0, 2'd3, 2'd0, 0, 0, 32'h0,        32'h500,      26'h0, 2'd2, 0, 32'hFE,       32'h100,      2, 1, 0);
    step("double_fault", 0, 0, 2'd0, 2'd0, 0, 0, 32'h0,        32'h0,        26'h0, 2'd3, 0, 32'hFE,       32'h100,      2, 0, 1);
    step("halt_wr_eret", 1, 0, 2'd3, 2'd0, 0, 0, 32'h0,        32'h500,      26'h0, 2'd0, 1, 32'hFE,       32'h100,      2, 0, 1);
    step("halt_exc",     0, 0, 2'd0, 2'd0, 0, 0, 32'h0,        32'h0,        26'h0, 2'd1, 0, 32'hFE,       32'h100,      2, 0, 1);
    async_reset("reset_from_halt");

    step("exc_div_wrap", 0, 0, 2'd0, 2'd0, 0, 0, 32'h0,        32'h0,        26'h0, 2'd3, 0, 32'hFF,       32'hFFFFFFFC, 3, 1, 0);
    step("eret_wrap",    0, 0, 2'd0, 2'd0, 0, 0, 32'h0,        32'h0,        26'h0, 2'd0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 3, 0, 0);
    step("load_8",       1, 0, 2'd3, 2'd0, 0, 0, 32'h0,        32'h8,        26'h0, 2'd0, 0, 32'h8,        32'hFFFFFFFC, 3, 0, 0);
    step("exc_opc",      0, 0, 2'd0, 2'd0, 0, 0, 32'h0,        32'h0,        26'h0, 2'd1, 0, 32'hFD,       32'h4,        1, 1, 0);

    @(negedge clk);
    idle();
    #1 ->mon_ev;
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the multicycle MIPS datapath; replaces the bare PC register plus external source mux. Holds PC, EPC and cause registers. Performs next-PC selection (sequential, branch target, jump, register, EPC return, exception vector), conditional-branch evaluation and single-level exception entry and return. Double-fault detection freezes the core until reset.

## Interface
- WIDTH, 32, PC/data width; must be ≥ 32.
- INC, 4, sequential increment.
- RESET_VECTOR, 0, PC value after reset.
- EXC_VECTOR_OPC, 32'hFD, handler address for invalid opcode.
- EXC_VECTOR_OVF, 32'hFE, handler address for overflow.
- EXC_VECTOR_DIV, 32'hFF, handler address for divide-by-zero.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- pc_wr  input  1  unconditional PC write.
- pc_wr_cond  input  1  conditional PC write (branch).
- pc_src  input  2  00 pc_plus, 01 alu_result, 10 jump target, 11 reg_a.
- branch_type  input  2  00 BEQ, 01 BNE, 10 BGT, 11 BLE.
- alu_zero  input  1  ALU zero flag.
- alu_gt  input  1  ALU greater-than flag.
- alu_result  input  WIDTH  branch target / ALUOut.
- reg_a  input  WIDTH  register operand for jr.
- jump_index  input  26  instruction bits [25:0].
- exc_code  input  2  00 none, 01 opcode, 10 overflow, 11 div-by-zero.
- eret  input  1  return from exception.
- pc_out  output  WIDTH  current PC.
- pc_plus  output  WIDTH  pc_out + INC (combinational).
- epc_out  output  WIDTH  exception PC.
- cause_out  output  2  last exception code.
- exc_active  output  1  handler in progress.
- halted  output  1  double fault, core frozen.

## Operation
- FSM states: RUN (exc_active=0), EXC (exc_active=1), HALT (halted=1).
- Per-cycle priority: exception > eret > pc_wr > pc_wr_cond > hold.
- Exception (exc_code≠00) in RUN: PC ← vector for code; EPC ← pc_out − INC (PC already incremented at fetch); cause ← exc_code; go EXC.
- Exception in EXC: go HALT; PC, EPC and cause unchanged.
- eret in EXC: PC ← EPC; go RUN. eret in RUN: ignored.
- pc_wr: PC ← selected source. Jump target = {pc_out[WIDTH-1:28], jump_index, 2'b00}.
- pc_wr_cond: PC ← selected source only if the condition holds. BEQ: alu_zero. BNE: !alu_zero. BGT: alu_gt. BLE: !alu_gt.
- pc_wr and pc_wr_cond together: pc_wr wins.
- HALT: all inputs ignored; only reset exits.
- Arithmetic is modulo 2^WIDTH. pc_plus and EPC wrap with no flag.
- Vectors are zero-extended to WIDTH.

## Timing
- Reset asserted: immediately, independent of clk, pc_out=RESET_VECTOR, epc_out=0, cause_out=0, exc_active=0, halted=0. Reset mid-exception or mid-HALT clears everything.
- First edge after reset deassertion acts normally.
- Writes, exception entry and eret take effect on the edge the request is sampled; new pc_out is visible 1 cycle after the request.
- pc_plus follows pc_out combinationally, with zero latency.
- exc_active and halted are registered and change on the same edge as PC.
- Requests are level-sampled each edge; no handshake. A request held for N cycles acts N times, e.g. a repeated pc_wr with src 00 advances PC N times.

## Test plan
- Reset, then 3 cycles of pc_wr with src 00 -> pc_out 0, 4, 8, 12. Assert reset asynchronously mid-cycle -> pc_out 0 at once.
- Load 0xFFFFFFFC via src 11, then pc_wr src 00 -> pc_out 0x00000000 (wrap), pc_plus 0x4.
- pc_wr_cond BEQ, alu_result 0x40: alu_zero=0 -> PC unchanged; alu_zero=1 -> 0x40. BLE with alu_gt=1 -> unchanged. BNE with alu_zero=0 -> taken.
- pc_out 0x10000004, pc_wr src 10, jump_index 0x0000010 -> pc_out 0x10000040.
- pc_out 0x108, exc_code 10 -> pc_out 0xFE, epc_out 0x104, cause_out 2, exc_active 1. Then eret -> pc_out 0x104, exc_active 0. Then exc_code 10 with pc_wr in the same cycle -> exception wins.
- In EXC, exc_code 11 -> halted 1 and PC frozen; later pc_wr and eret have no effect. Asserting reset -> all outputs return to reset values.
